// File: rtl/pin_auth.sv
// rtl/pin_auth.sv - PIN entry and card authentication ahead of the ATM control FSM
// Collects four BCD digits, checks them against PIN_VALUE, and locks the card after MAX_TRIES failures.
module pin_auth #(
  parameter logic [15:0] PIN_VALUE      = 16'h1234,
  parameter logic [1:0]  MAX_TRIES      = 2'd3,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000,
  parameter logic [23:0] DENY_HOLD      = 24'd5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       card_inserted,
  input  logic [3:0] digit_in,
  input  logic       digit_valid,
  input  logic       pin_clear,
  output logic [1:0] card_status,
  output logic [2:0] digit_count,
  output logic [1:0] tries_left,
  output logic       locked,
  output logic       entry_active,
  output logic       beep_pulse
);

  typedef enum logic [2:0] {
    WAIT_CARD,
    ENTER,
    CHECK,
    GRANTED,
    DENIED,
    LOCKED
  } state_t;

  state_t      state, state_d;
  logic [15:0] pin_buf, pin_buf_d;
  logic [2:0]  count_d;
  logic [1:0]  tries_d;
  logic [23:0] idle_timer, idle_timer_d;
  logic [23:0] hold_timer, hold_timer_d;
  logic        forced, forced_d;
  logic        beep_d;
  logic [1:0]  status_d;
  logic        digit_ok;

  assign digit_ok = digit_valid && (digit_in <= 4'd9);

  // Timers default to zero so any exit from their state clears them.
  always_comb begin
    state_d      = state;
    pin_buf_d    = pin_buf;
    count_d      = digit_count;
    tries_d      = tries_left;
    idle_timer_d = '0;
    hold_timer_d = '0;
    forced_d     = 1'b0;
    beep_d       = 1'b0;
    unique case (state)
      WAIT_CARD: begin
        if (card_inserted) begin
          state_d   = ENTER;
          pin_buf_d = '0;
          count_d   = '0;
          tries_d   = MAX_TRIES;
        end
      end
      ENTER: begin
        if (!card_inserted) begin
          state_d = WAIT_CARD;
        end else if (pin_clear) begin
          pin_buf_d = '0;
          count_d   = '0;
        end else if (digit_ok) begin
          pin_buf_d = {pin_buf[11:0], digit_in};
          count_d   = digit_count + 3'd1;
          beep_d    = 1'b1;
          if (digit_count == 3'd3) state_d = CHECK;
        end else if (idle_timer == TIMEOUT_CYCLES - 24'd1) begin
          state_d  = CHECK;
          forced_d = 1'b1;
        end else begin
          idle_timer_d = idle_timer + 24'd1;
        end
      end
      CHECK: begin
        if (!forced && (pin_buf == PIN_VALUE)) begin
          state_d = GRANTED;
        end else if (tries_left <= 2'd1) begin
          tries_d = 2'd0;
          state_d = LOCKED;
        end else begin
          tries_d = tries_left - 2'd1;
          state_d = DENIED;
        end
      end
      GRANTED: begin
        if (!card_inserted) state_d = WAIT_CARD;
      end
      DENIED: begin
        if (!card_inserted) begin
          state_d = WAIT_CARD;
        end else if (hold_timer == DENY_HOLD - 24'd1) begin
          state_d   = ENTER;
          pin_buf_d = '0;
          count_d   = '0;
        end else begin
          hold_timer_d = hold_timer + 24'd1;
        end
      end
      LOCKED: begin
        state_d = LOCKED;
      end
      default: begin
        state_d = WAIT_CARD;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    status_d = 2'b00;
    case (state_d)
      GRANTED: status_d = 2'b10;
      DENIED:  status_d = 2'b01;
      LOCKED:  status_d = card_inserted ? 2'b01 : 2'b00;
      default: status_d = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= WAIT_CARD;
      pin_buf      <= '0;
      idle_timer   <= '0;
      hold_timer   <= '0;
      forced       <= 1'b0;
      card_status  <= 2'b00;
      digit_count  <= 3'd0;
      tries_left   <= MAX_TRIES;
      locked       <= 1'b0;
      entry_active <= 1'b0;
      beep_pulse   <= 1'b0;
    end else begin
      state        <= state_d;
      pin_buf      <= pin_buf_d;
      idle_timer   <= idle_timer_d;
      hold_timer   <= hold_timer_d;
      forced       <= forced_d;
      card_status  <= status_d;
      digit_count  <= count_d;
      tries_left   <= tries_d;
      locked       <= (state_d == LOCKED);
      entry_active <= (state_d == ENTER);
      beep_pulse   <= beep_d;
    end
  end

endmodule

// File: tb/tb_pin_auth.sv
// tb/tb_pin_auth.sv - scoreboard bench for pin_auth
module tb_pin_auth;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       card_inserted = 1'b0;
  logic [3:0] digit_in = 4'd0;
  logic       digit_valid = 1'b0;
  logic       pin_clear = 1'b0;
  logic [1:0] card_status;
  logic [2:0] digit_count;
  logic [1:0] tries_left;
  logic       locked;
  logic       entry_active;
  logic       beep_pulse;

  pin_auth #(
    .PIN_VALUE(16'h1234),
    .MAX_TRIES(2'd3),
    .TIMEOUT_CYCLES(24'd20),
    .DENY_HOLD(24'd4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .card_inserted(card_inserted),
    .digit_in(digit_in),
    .digit_valid(digit_valid),
    .pin_clear(pin_clear),
    .card_status(card_status),
    .digit_count(digit_count),
    .tries_left(tries_left),
    .locked(locked),
    .entry_active(entry_active),
    .beep_pulse(beep_pulse)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  logic [2:0] beep_q[$];
  logic [4:0] verdict_q[$];
  int m_count = 0;
  logic [1:0] m_tries = 2'd3;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: beeps and attempt verdicts are matched against the queues.
  logic [1:0] prev_cs = 2'b00;
  logic ea_d1 = 1'b0;
  logic ea_d2 = 1'b0;
  always @(negedge clk) begin
    logic [4:0] v;
    logic [2:0] c;
    if (beep_pulse) begin
      check_eq("beep_expected", beep_q.size() > 0, 1);
      if (beep_q.size() > 0) begin
        c = beep_q.pop_front();
        check_eq("beep_count", digit_count, c);
      end
    end
    if (card_status != 2'b00 && prev_cs == 2'b00 && ea_d2) begin
      check_eq("verdict_expected", verdict_q.size() > 0, 1);
      if (verdict_q.size() > 0) begin
        v = verdict_q.pop_front();
        check_eq("verdict_status", card_status, v[4:3]);
        check_eq("verdict_tries", tries_left, v[2:1]);
        check_eq("verdict_locked", locked, v[0]);
      end
    end
    ea_d2   <= ea_d1;
    ea_d1   <= entry_active;
    prev_cs <= card_status;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    if (d <= 4'd9) begin
      m_count++;
      beep_q.push_back(3'(m_count));
    end
    digit_in    = d;
    digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
  endtask

  task automatic push_verdict(input logic ok);
    if (ok) begin
      verdict_q.push_back({2'b10, m_tries, 1'b0});
    end else begin
      if (m_tries > 2'd0) m_tries = m_tries - 2'd1;
      verdict_q.push_back({2'b01, m_tries, m_tries == 2'd0});
    end
  endtask

  task automatic enter_pin(input logic [15:0] pin);
    logic [15:0] p;
    p = pin;
    for (int i = 0; i < 3; i++) begin
      press(p[15-4*i -: 4]);
      tick();
    end
    push_verdict(p == 16'h1234);
    press(p[3:0]);
    m_count = 0;
    check_eq("check_cycle_status", card_status, 2'b00);
    tick();
    check_eq("verdict_edge", card_status, (p == 16'h1234) ? 2'b10 : 2'b01);
  endtask

  task automatic wait_enter(input string tag, input int budget);
    int n;
    n = 0;
    while (!entry_active && n < budget) begin
      tick();
      n++;
    end
    check_eq(tag, entry_active, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_cs"}, card_status, 2'b00);
    check_eq({tag, "_dc"}, digit_count, 3'd0);
    check_eq({tag, "_tries"}, tries_left, 2'd3);
    check_eq({tag, "_locked"}, locked, 1'b0);
    check_eq({tag, "_ea"}, entry_active, 1'b0);
    check_eq({tag, "_beep"}, beep_pulse, 1'b0);
  endtask

  initial begin
    int n;
    rst = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b1;

    // Correct PIN, then card removal.
    card_inserted = 1'b1;
    tick();
    check_eq("enter_active", entry_active, 1'b1);
    check_eq("enter_dc", digit_count, 3'd0);
    enter_pin(16'h1234);
    card_inserted = 1'b0;
    tick();
    check_eq("removed_cs", card_status, 2'b00);

    // Wrong PIN, hold, then correct PIN.
    card_inserted = 1'b1;
    tick();
    enter_pin(16'h1235);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("deny_hold", card_status, 2'b01);
    end
    tick();
    check_eq("deny_release_cs", card_status, 2'b00);
    check_eq("deny_release_ea", entry_active, 1'b1);
    check_eq("deny_release_dc", digit_count, 3'd0);
    enter_pin(16'h1234);
    card_inserted = 1'b0;
    tick();

    // Three failures lead to lockout.
    card_inserted = 1'b1;
    m_tries = 2'd3;
    tick();
    enter_pin(16'h9999);
    wait_enter("hold_done_1", 10);
    enter_pin(16'h0000);
    wait_enter("hold_done_2", 10);
    enter_pin(16'h4321);
    check_eq("lock_flag", locked, 1'b1);
    check_eq("lock_tries", tries_left, 2'd0);
    card_inserted = 1'b0;
    tick();
    check_eq("lock_removed_cs", card_status, 2'b00);
    check_eq("lock_removed_flag", locked, 1'b1);
    card_inserted = 1'b1;
    tick();
    check_eq("lock_reinsert_cs", card_status, 2'b01);
    check_eq("lock_reinsert_tries", tries_left, 2'd0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_reset_outputs("lock_reset");
    m_tries = 2'd3;

    // Clear wins over digit; out-of-range digit is ignored.
    tick();
    press(4'd1);
    tick();
    press(4'd2);
    tick();
    pin_clear   = 1'b1;
    digit_in    = 4'd3;
    digit_valid = 1'b1;
    tick();
    pin_clear   = 1'b0;
    digit_valid = 1'b0;
    m_count     = 0;
    check_eq("clear_dc", digit_count, 3'd0);
    press(4'hA);
    check_eq("bad_digit_beep", beep_pulse, 1'b0);
    check_eq("bad_digit_dc", digit_count, 3'd0);
    tick();
    enter_pin(16'h1234);
    card_inserted = 1'b0;
    tick();

    // Inactivity timeout counts as a failure.
    card_inserted = 1'b1;
    tick();
    push_verdict(1'b0);
    n = 0;
    while (card_status == 2'b00 && n < 60) begin
      tick();
      n++;
    end
    check_eq("timeout_cycles", n, 21);
    check_eq("timeout_tries", tries_left, 2'd2);
    wait_enter("timeout_hold", 10);
    press(4'd1);
    tick();
    press(4'd2);
    tick();
    card_inserted = 1'b0;
    m_count = 0;
    tick();
    check_eq("removal_ea", entry_active, 1'b0);
    check_eq("removal_tries", tries_left, 2'd2);

    // Reset in the middle of an entry.
    card_inserted = 1'b1;
    m_tries = 2'd3;
    tick();
    press(4'd1);
    tick();
    press(4'd2);
    tick();
    press(4'd3);
    tick();
    check_eq("mid_entry_dc", digit_count, 3'd3);
    rst = 1'b0;
    m_count = 0;
    tick();
    rst = 1'b1;
    check_reset_outputs("mid_reset");

    tick();
    tick();
    check_eq("beep_q_drained", beep_q.size(), 0);
    check_eq("verdict_q_drained", verdict_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pin_auth.md
Name: pin_auth

Overview:
- PIN-entry and card-authentication stage placed directly upstream of the ATM control FSM.
- Drives that FSM's 2-bit card input: 00 = no card, 01 = invalid, 10 = valid.
- Collects four BCD digits from the debounced keypad, compares them against a stored PIN, counts failed attempts and locks the card out permanently after MAX_TRIES failures.
- Includes an inactivity timeout and a hold time on denial.

Parameters:
- PIN_VALUE, 16'h1234: stored PIN as four BCD nibbles. The first digit entered is the most significant nibble.
- MAX_TRIES, 3: failed attempts allowed before lockout. Range 1..3.
- TIMEOUT_CYCLES, 24'd10_000_000: ENTER-state inactivity limit, in clk cycles.
- DENY_HOLD, 24'd5_000_000: number of cycles card_status is held at 01 after a failed attempt.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: reset, synchronous, active-low. rst==0 at a rising clk edge resets the block.
- card_inserted, input, 1: card-present switch, level.
- digit_in, input, 4: keypad digit, BCD.
- digit_valid, input, 1: one-cycle strobe; digit_in is valid in this cycle.
- pin_clear, input, 1: one-cycle strobe; discards the partial entry.
- card_status, output, 2: to the FSM card input. 00 none, 01 invalid, 10 valid.
- digit_count, output, 3: digits accepted so far in the current entry, 0..4.
- tries_left, output, 2: remaining attempts.
- locked, output, 1: lockout flag.
- entry_active, output, 1: high while in ENTER.
- beep_pulse, output, 1: one-cycle pulse per accepted digit.

Behaviour:
- All outputs are registered. The state register, buffer, counters and timers update on rising clk.
- Reset (rst==0) sets:
  - state = WAIT_CARD, card_status = 00, digit_count = 0, tries_left = MAX_TRIES, locked = 0;
  - entry_active = 0, beep_pulse = 0, pin buffer = 0, both timers = 0.
- Reset overrides every other input in the same cycle. This also applies mid-operation, including from LOCKED.
- States are WAIT_CARD, ENTER, CHECK, GRANTED, DENIED, LOCKED.
- WAIT_CARD:
  - card_status = 00.
  - If card_inserted==1: go to ENTER, clear the buffer and digit_count, and reload tries_left = MAX_TRIES.
- ENTER (entry_active = 1, card_status = 00):
  - card_inserted==0 → WAIT_CARD. No attempt is charged.
  - pin_clear==1 → buffer = 0, digit_count = 0, timer = 0. pin_clear wins over a simultaneous digit_valid.
  - digit_valid with digit_in ≤ 9 → buffer = {buffer[11:0], digit_in}, digit_count + 1, timer = 0, beep_pulse = 1 for one cycle.
  - digit_valid with digit_in > 9 → ignored entirely. No count, no beep, no timer restart.
  - On the edge that accepts the 4th digit, state becomes CHECK.
  - Otherwise the inactivity timer increments. When it reaches TIMEOUT_CYCLES-1, go to CHECK with a forced mismatch.
- CHECK (exactly one cycle):
  - buffer == PIN_VALUE and not forced → GRANTED.
  - Else tries_left decrements. If the new value is 0 → LOCKED, else → DENIED.
  - Latency: 4th digit strobe sampled at edge N → CHECK at N → card_status = 10 or 01 after edge N+1.
- GRANTED:
  - card_status = 10 while card_inserted==1.
  - On card removal → WAIT_CARD, with card_status = 00 after that edge.
  - Keypad input is ignored.
- DENIED:
  - card_status = 01 and the hold timer counts.
  - After DENY_HOLD cycles → ENTER with buffer and digit_count cleared, card_status = 00.
  - Card removal during the hold → WAIT_CARD immediately.
- LOCKED:
  - locked = 1, card_status = 01 while card_inserted==1, 00 otherwise.
  - Reinsertion does not reload tries_left and does not leave LOCKED. Only reset exits this state.
- Boundary and arithmetic rules:
  - tries_left never underflows.
  - digit_count saturates at 4; it cannot exceed 4 because of the CHECK transition.
  - The timers never wrap: they clear on every state exit.
  - Keypad strobes arriving in CHECK, DENIED, GRANTED or LOCKED are dropped.

Test Plan (TIMEOUT_CYCLES=20, DENY_HOLD=4, PIN_VALUE=16'h1234, MAX_TRIES=3):
- Reset then insert card, enter digits 1,2,3,4 → four beep_pulses, digit_count 1..4, card_status = 10 two edges after the 4th strobe; remove card → 00 next edge.
- Enter 1,2,3,5 → card_status = 01 for 4 cycles, tries_left = 2, then ENTER with digit_count = 0; enter 1,2,3,4 → 10.
- Three wrong PINs → tries_left 2,1,0, locked = 1, card_status = 01; remove card → 00; reinsert → 01 immediately; rst=0 for one edge → WAIT_CARD, tries_left = 3, locked = 0.
- Enter 1,2, then pin_clear asserted together with digit_valid=3 → digit_count = 0; digit_in = 4'hA strobe → ignored, no beep; then 1,2,3,4 → 10.
- Insert card, no keys for 20 cycles → counts as a failure: card_status = 01, tries_left = 2; remove card mid-entry after 2 digits → WAIT_CARD, tries_left unchanged.
- Assert rst mid-ENTER with digit_count = 3 → all outputs at reset values on the next edge.
